// File: rtl/acc_seq_pkg.sv
// -----------------------------------------------------------------------------
// acc_seq_pkg
// Shared definitions for the accumulate-and-write sequencer: the FSM state
// encoding and the default data width, address width and beats-per-word.
// -----------------------------------------------------------------------------
package acc_seq_pkg;

   localparam int DW_DEF    = 16;
   localparam int AW_DEF    = 8;
   localparam int BEATS_DEF = 25;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      CAPT  = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/acc_seq.sv
// -----------------------------------------------------------------------------
// acc_seq
// Sequencer for an external accumulator. Each job produces num_out output
// words; each word is the sum of BEATS accepted input beats. The sequencer
// paces the upstream beats, strobes the accumulator (clear on the first beat
// of every window), captures the accumulated sum and writes it to an output
// buffer at consecutive addresses starting at base_addr.
//
// Optional feature (macro ACC_SEQ_RELU_EN): when defined, a negative captured
// sum (sign bit set) is stored as zero; otherwise the sum is stored unchanged.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle job start, honoured only in IDLE
//   num_out         words per job, sampled on start (0 = empty job)
//   base_addr       first write address, sampled on start
//   beat_valid      upstream beat available
//   beat_ready      sequencer accepts a beat (RUN only)
//   acc_enable      accumulator enable (= beat_valid & beat_ready)
//   acc_clear       accumulator load instead of add (first beat of a window)
//   acc_sum         registered accumulator result
//   wr_en/wr_ready  output buffer write handshake
//   wr_addr/wr_data write address / data, stable while wr_en is pending
//   busy            job in progress
//   done            one-cycle pulse at job end
// -----------------------------------------------------------------------------
module acc_seq
   import acc_seq_pkg::*;
#(
   parameter int BEATS = BEATS_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    num_out,
   input  logic [AW-1:0] base_addr,
   input  logic          beat_valid,
   output logic          beat_ready,
   output logic          acc_enable,
   output logic          acc_clear,
   input  logic [DW-1:0] acc_sum,
   output logic          wr_en,
   input  logic          wr_ready,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          done
);

   localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

   state_t     state, state_nx;
   logic [7:0] beat_cnt;
   logic [7:0] wr_cnt;
   logic [7:0] num_q;
   logic       last_beat;
   logic       wr_acc;
   logic       start_ok;

   // Captured-sum post-processing: optional clamp of negative sums to zero.
   function automatic logic [DW-1:0] post_proc(input logic signed [DW-1:0] s);
`ifdef ACC_SEQ_RELU_EN
      return s[DW-1] ? '0 : $unsigned(s);
`else
      return $unsigned(s);
`endif
   endfunction

   assign start_ok   = (state == IDLE) && start;
   assign acc_enable = beat_valid & beat_ready;
   assign last_beat  = acc_enable && (beat_cnt == LAST_BEAT);
   assign wr_acc     = wr_en & wr_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nx   = state;
      beat_ready = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      acc_clear  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (num_out == 8'd0) ? FIN : RUN;
         end
         RUN: begin
            beat_ready = 1'b1;
            // Gated to RUN so the strobe is quiet in IDLE and under reset.
            acc_clear  = (beat_cnt == 8'd0);
            if (last_beat) state_nx = CAPT;
         end
         CAPT: state_nx = WRITE;
         WRITE: begin
            wr_en = 1'b1;
            if (wr_ready) state_nx = ((wr_cnt + 8'd1) == num_q) ? FIN : RUN;
         end
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Job parameters, counters, write address and captured data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q    <= '0;
         beat_cnt <= '0;
         wr_cnt   <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         if (start_ok) begin
            num_q    <= num_out;
            wr_addr  <= base_addr;
            beat_cnt <= '0;
            wr_cnt   <= '0;
         end
         if (acc_enable) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
         if (state == CAPT) wr_data <= post_proc($signed(acc_sum));
         if (wr_acc) begin
            wr_addr <= wr_addr + 1'b1;
            wr_cnt  <= wr_cnt + 8'd1;
         end
      end
   end

endmodule
